// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared types and constants for the unified-memory arbiter.
// Used by mem_arb_rr_pick and mem_arbiter.
package mem_arb_pkg;

   // Default address and data widths (byte address, 32-bit words).
   localparam int AW_DEF = 32;
   localparam int DW_DEF = 32;

   // Width of the latency down-counter; holds any MEM_LAT in 1..15.
   localparam int CNT_W = 4;

   // Arbiter FSM states.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Requester identifiers; REQ_DATA is the reset value of last_grant.
   typedef enum logic {
      REQ_IF   = 1'b0,
      REQ_DATA = 1'b1
   } req_id_t;

   // The requester that was not served last time.
   function automatic logic other_req(input logic id);
      return ~id;
   endfunction

endpackage

// File: rtl/mem_arb_rr_pick.sv
// mem_arb_rr_pick: combinational round-robin picker for the two requesters.
// A lone requester always wins; on a tie the requester not granted last wins.
module mem_arb_rr_pick
   import mem_arb_pkg::*;
(
   input  logic if_req,
   input  logic d_req,
   input  logic last_grant,
   output logic grant_valid,
   output logic grant_id
);

   // Choose the winner from the current requests and the previous grant.
   always_comb begin
      grant_valid = if_req | d_req;
      grant_id    = REQ_IF;
      if (if_req && d_req) begin
         grant_id = other_req(last_grant);
      end else if (d_req) begin
         grant_id = REQ_DATA;
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-ported fixed-latency memory between the
// instruction-fetch port and the data load/store port. One transaction is in
// flight at a time: a decision cycle (IDLE), MEM_LAT access cycles (WAIT) and
// a one-cycle response (RESP) that carries the requester's ack.
// Optional build macro MEM_ARB_PERF_EN adds grant/conflict counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW      = AW_DEF,
   parameter int DW      = DW_DEF,
   parameter int MEM_LAT = 1
)(
   input  logic          clk,
   input  logic          rst,
   input  logic          if_req,
   input  logic [AW-1:0] if_addr,
   output logic          if_ack,
   output logic [DW-1:0] if_rdata,
   input  logic          d_req,
   input  logic          d_we,
   input  logic [AW-1:0] d_addr,
   input  logic [DW-1:0] d_wdata,
   output logic          d_ack,
   output logic [DW-1:0] d_rdata,
   output logic          mem_en,
   output logic          mem_we,
   output logic [AW-1:0] mem_addr,
   output logic [DW-1:0] mem_wdata,
   input  logic [DW-1:0] mem_rdata,
   output logic          busy
`ifdef MEM_ARB_PERF_EN
   ,
   output logic [31:0]   perf_if_grants,
   output logic [31:0]   perf_d_grants,
   output logic [31:0]   perf_conflicts
`endif
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic             r_last_grant;
   logic             r_winner;
   logic             r_if_ack;
   logic             r_d_ack;
   logic [DW-1:0]    r_if_rdata;
   logic [DW-1:0]    r_d_rdata;
   logic             r_mem_en;
   logic             r_mem_we;
   logic             r_d_store;
   logic [AW-1:0]    r_mem_addr;
   logic [DW-1:0]    r_mem_wdata;
   logic             r_busy;

   logic             w_grant_valid;
   logic             w_grant_id;
   logic             w_grant_data;

   mem_arb_rr_pick u_pick (
      .if_req      (if_req),
      .d_req       (d_req),
      .last_grant  (r_last_grant),
      .grant_valid (w_grant_valid),
      .grant_id    (w_grant_id)
   );

   assign w_grant_data = (w_grant_id == REQ_DATA);

   // Arbiter FSM: latch the winner's request at grant, count down the memory
   // latency, then capture read data and pulse the winner's ack for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_cnt        <= '0;
         r_last_grant <= REQ_DATA;
         r_winner     <= REQ_IF;
         r_if_ack     <= 1'b0;
         r_d_ack      <= 1'b0;
         r_if_rdata   <= '0;
         r_d_rdata    <= '0;
         r_mem_en     <= 1'b0;
         r_mem_we     <= 1'b0;
         r_d_store    <= 1'b0;
         r_mem_addr   <= '0;
         r_mem_wdata  <= '0;
         r_busy       <= 1'b0;
      end else begin
         // Acks are single-cycle pulses unless set again below.
         r_if_ack <= 1'b0;
         r_d_ack  <= 1'b0;
         case (r_state)
            IDLE: begin
               if (w_grant_valid) begin
                  r_mem_en     <= 1'b1;
                  r_mem_we     <= w_grant_data & d_we;
                  r_d_store    <= w_grant_data & d_we;
                  // Fetches never write, so their write data is parked at zero.
                  r_mem_addr   <= w_grant_data ? d_addr : if_addr;
                  r_mem_wdata  <= w_grant_data ? d_wdata : '0;
                  r_winner     <= w_grant_id;
                  r_last_grant <= w_grant_id;
                  r_cnt        <= CNT_W'(MEM_LAT);
                  r_state      <= WAIT;
                  r_busy       <= 1'b1;
               end
            end
            WAIT: begin
               // The strobe lasts only the first WAIT cycle; address and data hold.
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
               r_cnt    <= r_cnt - CNT_W'(1);
               if (r_cnt == CNT_W'(1)) begin
                  if (r_winner == REQ_DATA) begin
                     r_d_ack <= 1'b1;
                     // Stores leave the load-data register untouched.
                     if (!r_d_store) begin
                        r_d_rdata <= mem_rdata;
                     end
                  end else begin
                     r_if_ack   <= 1'b1;
                     r_if_rdata <= mem_rdata;
                  end
                  r_state <= RESP;
               end
            end
            RESP: begin
               // Requesters may still show req here; ignore them for one cycle.
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
            default: begin
               r_state  <= IDLE;
               r_busy   <= 1'b0;
               r_mem_en <= 1'b0;
               r_mem_we <= 1'b0;
            end
         endcase
      end
   end

   assign if_ack    = r_if_ack;
   assign if_rdata  = r_if_rdata;
   assign d_ack     = r_d_ack;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_mem_addr;
   assign mem_wdata = r_mem_wdata;
   assign busy      = r_busy;

`ifdef MEM_ARB_PERF_EN
   logic [31:0] r_perf_if;
   logic [31:0] r_perf_d;
   logic [31:0] r_perf_conf;

   // Grant and conflict counters, bumped on the grant edge; they wrap freely.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_perf_if   <= '0;
         r_perf_d    <= '0;
         r_perf_conf <= '0;
      end else if (r_state == IDLE && w_grant_valid) begin
         if (w_grant_data) begin
            r_perf_d <= r_perf_d + 32'd1;
         end else begin
            r_perf_if <= r_perf_if + 32'd1;
         end
         if (if_req && d_req) begin
            r_perf_conf <= r_perf_conf + 32'd1;
         end
      end
   end

   assign perf_if_grants = r_perf_if;
   assign perf_d_grants  = r_perf_d;
   assign perf_conflicts = r_perf_conf;
`endif

endmodule
